// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the two-requester memory port arbiter.
// Tag layout is {requester id, per-requester sequence number}.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_BITS  = 28;
    localparam int MEM_TAG_BITS   = 5;
    localparam int MEM_DATA_BITS  = 128;
    localparam int BEATS_PER_LINE = 4;

    localparam logic REQ_ICACHE = 1'b0;
    localparam logic REQ_DCACHE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WDATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin pick: on a tie the requester not served last wins.
// The grant is one-hot and indexed by requester id.
module mem_rr_arb
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = valid_i;
        if (&valid_i) begin
            grant_o = (last_i == REQ_DCACHE) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory command/write-data port between icache (0) and dcache (1)
// and steers read responses back by the tag MSB.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_BITS,
    parameter int TAG_W  = MEM_TAG_BITS,
    parameter int DATA_W = MEM_DATA_BITS
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                r0_req_valid,
    output logic                r0_req_ready,
    input  logic                r0_req_rw,
    input  logic [ADDR_W-1:0]   r0_req_addr,
    input  logic                r0_data_valid,
    output logic                r0_data_ready,
    input  logic [DATA_W-1:0]   r0_data_bits,
    input  logic [DATA_W/8-1:0] r0_data_mask,
    output logic                r0_resp_valid,
    output logic [DATA_W-1:0]   r0_resp_data,
    output logic [1:0]          r0_resp_beat,

    input  logic                r1_req_valid,
    output logic                r1_req_ready,
    input  logic                r1_req_rw,
    input  logic [ADDR_W-1:0]   r1_req_addr,
    input  logic                r1_data_valid,
    output logic                r1_data_ready,
    input  logic [DATA_W-1:0]   r1_data_bits,
    input  logic [DATA_W/8-1:0] r1_data_mask,
    output logic                r1_resp_valid,
    output logic [DATA_W-1:0]   r1_resp_data,
    output logic [1:0]          r1_resp_beat,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_rw,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [TAG_W-1:0]    mem_req_tag,

    output logic                mem_req_data_valid,
    input  logic                mem_req_data_ready,
    output logic [DATA_W-1:0]   mem_req_data_bits,
    output logic [DATA_W/8-1:0] mem_req_data_mask,
    output logic [1:0]          mem_req_data_offset,

    input  logic                mem_resp_valid,
    input  logic [TAG_W-1:0]    mem_resp_tag,
    input  logic [DATA_W-1:0]   mem_resp_data,

    output logic [1:0]          dbg_state_o
);

    localparam int SEQ_W = TAG_W - 1;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_LINE - 1);

    // Handshakes: a transfer happens on a rising clk edge where valid and
    // ready are both high; valid and its payload hold until that edge.

    arb_state_e              state_q, state_d;
    logic                    last_q, last_d;
    logic [1:0][SEQ_W-1:0]   seq_q, seq_d;
    logic [1:0]              beat_q, beat_d;
    logic [1:0][1:0]         rbeat_q, rbeat_d;
    logic                    hold_rw_q, hold_rw_d;
    logic                    hold_id_q, hold_id_d;
    logic [ADDR_W-1:0]       hold_addr_q, hold_addr_d;
    logic [TAG_W-1:0]        hold_tag_q, hold_tag_d;

    logic [1:0]              req_valid, grant, req_ready, data_ready, resp_hit;
    logic                    unused_tag_bits;

    assign req_valid = {r1_req_valid, r0_req_valid};

    mem_rr_arb u_rr_arb (
        .valid_i (req_valid),
        .last_i  (last_q),
        .grant_o (grant)
    );

    always_comb begin
        state_d             = state_q;
        last_d              = last_q;
        seq_d               = seq_q;
        beat_d              = beat_q;
        hold_rw_d           = hold_rw_q;
        hold_id_d           = hold_id_q;
        hold_addr_d         = hold_addr_q;
        hold_tag_d          = hold_tag_q;
        req_ready           = 2'b00;
        data_ready          = 2'b00;
        mem_req_valid       = 1'b0;
        mem_req_rw          = 1'b0;
        mem_req_addr        = '0;
        mem_req_tag         = '0;
        mem_req_data_valid  = 1'b0;
        mem_req_data_bits   = '0;
        mem_req_data_mask   = '0;
        mem_req_data_offset = 2'd0;

        // Reset silences every handshake so an in-flight command is dropped.
        if (!reset) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        req_ready   = grant;
                        hold_id_d   = grant[1];
                        hold_rw_d   = grant[1] ? r1_req_rw : r0_req_rw;
                        hold_addr_d = grant[1] ? r1_req_addr : r0_req_addr;
                        hold_tag_d  = {grant[1], seq_q[grant[1]]};
                        state_d     = ST_CMD;
                    end
                end
                ST_CMD: begin
                    mem_req_valid = 1'b1;
                    mem_req_rw    = hold_rw_q;
                    mem_req_addr  = hold_addr_q;
                    mem_req_tag   = hold_tag_q;
                    if (mem_req_ready) begin
                        seq_d[hold_id_q] = seq_q[hold_id_q] + SEQ_W'(1);
                        last_d           = hold_id_q;
                        state_d          = hold_rw_q ? ST_WDATA : ST_IDLE;
                    end
                end
                ST_WDATA: begin
                    mem_req_data_valid    = hold_id_q ? r1_data_valid : r0_data_valid;
                    data_ready[hold_id_q] = mem_req_data_ready;
                    mem_req_data_bits     = hold_id_q ? r1_data_bits : r0_data_bits;
                    mem_req_data_mask     = hold_id_q ? r1_data_mask : r0_data_mask;
                    mem_req_data_offset   = beat_q;
                    if ((hold_id_q ? r1_data_valid : r0_data_valid) && mem_req_data_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            beat_d  = 2'd0;
                            state_d = ST_IDLE;
                        end else begin
                            beat_d = beat_q + 2'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        for (int n = 0; n < 2; n++) begin
            resp_hit[n] = !reset && mem_resp_valid && (mem_resp_tag[TAG_W-1] == n[0]);
            rbeat_d[n]  = resp_hit[n] ? rbeat_q[n] + 2'd1 : rbeat_q[n];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b0;
            seq_q       <= '0;
            beat_q      <= 2'd0;
            rbeat_q     <= '0;
            hold_rw_q   <= 1'b0;
            hold_id_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            seq_q       <= seq_d;
            beat_q      <= beat_d;
            rbeat_q     <= rbeat_d;
            hold_rw_q   <= hold_rw_d;
            hold_id_q   <= hold_id_d;
            hold_addr_q <= hold_addr_d;
            hold_tag_q  <= hold_tag_d;
        end
    end

    assign r0_req_ready  = req_ready[0];
    assign r1_req_ready  = req_ready[1];
    assign r0_data_ready = data_ready[0];
    assign r1_data_ready = data_ready[1];
    assign r0_resp_valid = resp_hit[0];
    assign r1_resp_valid = resp_hit[1];
    assign r0_resp_data  = reset ? '0 : mem_resp_data;
    assign r1_resp_data  = reset ? '0 : mem_resp_data;
    assign r0_resp_beat  = rbeat_q[0];
    assign r1_resp_beat  = rbeat_q[1];
    assign dbg_state_o   = state_q;

    // Only the requester-id bit of a response tag steers routing.
    assign unused_tag_bits = ^mem_resp_tag[TAG_W-2:0];

endmodule
